fifo_ctrl: RTL and testbench

Pointer and occupancy controller for the 4-entry x 64-bit FIFO storage array (`fifo_mem`). It accepts push and pop requests from the producer and consumer, and generates `write_ptr`, `read_ptr`, `write` and `read` for the storage array. It also reports `full`, `empty`, `count` and protocol errors. `fifo_ctrl` and `fifo_mem` are instantiated side by side inside the top-level `fifo` wrapper; the data path never passes through this block.

---
 rtl/fifo_defs_pkg.sv | 15 +
 rtl/fifo_ctrl_ptr_counter.sv | 27 ++
 rtl/fifo_ctrl.sv | 72 +++++++
 tb/tb_fifo_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_defs_pkg.sv
// Shared FIFO constants used by the controller, the storage array and the wrapper.
package fifo_defs_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;
  localparam int DATA_W     = 64;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_FULL  = cnt_t'(FIFO_DEPTH);
  localparam cnt_t CNT_EMPTY = '0;

endpackage

// File: rtl/fifo_ctrl_ptr_counter.sv
// Wrapping pointer counter with synchronous reset and increment enable.
module ptr_counter
  import fifo_defs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  ptr_t ptr_q;
  ptr_t ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + ptr_t'(1);
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and error controller for the 4-entry FIFO storage array.
module fifo_ctrl
  import fifo_defs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in_valid,
  input  logic             pop_fifo,
  output logic [PTR_W-1:0] write_ptr,
  output logic [PTR_W-1:0] read_ptr,
  output logic             write,
  output logic             read,
  output logic             data_out_valid,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  cnt_t count_q, count_d;
  logic err_q, err_d;
  logic push_ok, pop_ok;

  // Full and empty come from registered count only, so write never loops back into them.
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == CNT_EMPTY);

  // Requests in the reset cycle are discarded, so the array is not written either.
  assign push_ok = data_in_valid & ~fifo_full & ~rst;
  assign pop_ok  = pop_fifo & ~fifo_empty & ~rst;

  ptr_counter u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push_ok),
    .ptr_o (write_ptr)
  );

  ptr_counter u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop_ok),
    .ptr_o (read_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
    err_d = (data_in_valid & fifo_full) | (pop_fifo & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign write          = push_ok;
  assign read           = ~fifo_empty;
  assign data_out_valid = ~fifo_empty;
  assign count          = count_q;
  assign err            = err_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with hand-computed expectations.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       data_in_valid;
  logic       pop_fifo;
  logic [1:0] write_ptr;
  logic [1:0] read_ptr;
  logic       write;
  logic       read;
  logic       data_out_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] count;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;

  fifo_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .pop_fifo       (pop_fifo),
    .write_ptr      (write_ptr),
    .read_ptr       (read_ptr),
    .write          (write),
    .read           (read),
    .data_out_valid (data_out_valid),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .count          (count),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply requests mid-cycle and let combinational outputs settle.
  task automatic drive(input logic push, input logic pop);
    data_in_valid = push;
    pop_fifo      = pop;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    data_in_valid = 1'b1;
    pop_fifo      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0);

    // Reset state
    check("rst_wptr",  write_ptr,      0);
    check("rst_rptr",  read_ptr,       0);
    check("rst_write", write,          0);
    check("rst_read",  read,           0);
    check("rst_dov",   data_out_valid, 0);
    check("rst_full",  fifo_full,      0);
    check("rst_empty", fifo_empty,     1);
    check("rst_count", count,          0);
    check("rst_err",   err,            0);

    // Fill with four pushes
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      check($sformatf("fill_wptr%0d", i), write_ptr, 8'(i));
      check($sformatf("fill_write%0d", i), write, 1);
      tick();
      check($sformatf("fill_count%0d", i), count, 8'(i + 1));
      check($sformatf("fill_full%0d", i), fifo_full, (i == 3) ? 8'd1 : 8'd0);
      check($sformatf("fill_dov%0d", i), data_out_valid, 1);
    end

    // Push into full is rejected
    drive(1'b1, 1'b0);
    check("ovf_write", write, 0);
    tick();
    check("ovf_err",   err,       1);
    check("ovf_count", count,     4);
    check("ovf_wptr",  write_ptr, 0);
    drive(1'b0, 1'b0);
    tick();
    check("ovf_err_clr", err, 0);

    // Drain with four pops
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      check($sformatf("drain_rptr%0d", i), read_ptr, 8'(i));
      check($sformatf("drain_read%0d", i), read, 1);
      tick();
      check($sformatf("drain_count%0d", i), count, 8'(3 - i));
      check($sformatf("drain_empty%0d", i), fifo_empty, (i == 3) ? 8'd1 : 8'd0);
    end

    // Pop from empty is rejected
    drive(1'b0, 1'b1);
    check("udf_read", read, 0);
    tick();
    check("udf_err",   err,      1);
    check("udf_rptr",  read_ptr, 0);
    check("udf_count", count,    0);

    // Wrap-around: 3 pushes, 3 pops, 2 pushes
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0); tick(); end
    check("wrap_err_clr", err, 0);
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1); tick(); end
    drive(1'b1, 1'b0);
    check("wrap_wptr3", write_ptr, 3);
    tick();
    drive(1'b1, 1'b0);
    check("wrap_wptr0", write_ptr, 0);
    tick();
    drive(1'b0, 1'b0);
    check("wrap_count", count,    2);
    check("wrap_rptr",  read_ptr, 3);

    // Simultaneous push and pop at count 2 (wr=1, rd=3)
    drive(1'b1, 1'b1);
    check("mid_write", write, 1);
    tick();
    check("mid_count", count,     2);
    check("mid_wptr",  write_ptr, 2);
    check("mid_rptr",  read_ptr,  0);
    check("mid_err",   err,       0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0); tick(); end
    drive(1'b1, 1'b1);
    check("full_both_write", write, 0);
    tick();
    check("full_both_count", count,     3);
    check("full_both_err",   err,       1);
    check("full_both_rptr",  read_ptr,  1);
    check("full_both_wptr",  write_ptr, 0);

    // Simultaneous push and pop at empty
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1); tick(); end
    check("empty_before", fifo_empty, 1);
    drive(1'b1, 1'b1);
    check("empty_both_write", write, 1);
    check("empty_both_read",  read,  0);
    tick();
    check("empty_both_count", count,          1);
    check("empty_both_dov",   data_out_valid, 1);
    check("empty_both_err",   err,            1);
    check("empty_both_wptr",  write_ptr,      1);
    check("empty_both_rptr",  read_ptr,       0);

    // Reset mid-operation at count 3, wr_ptr 3, with a push in the reset cycle
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0); tick(); end
    check("pre_rst_count", count,     3);
    check("pre_rst_wptr",  write_ptr, 3);
    rst = 1'b1;
    drive(1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0);
    check("mrst_wptr",  write_ptr,  0);
    check("mrst_rptr",  read_ptr,   0);
    check("mrst_count", count,      0);
    check("mrst_empty", fifo_empty, 1);
    check("mrst_err",   err,        0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
